parity_uart_rx: RTL and testbench
=================================

Name: parity_uart_rx

Overview:
- Serial receiver counterpart to the team's XOR-based parity transmit path.
- Deserialises one async-serial frame: start bit, DATA_W data bits LSB-first, one parity bit, one stop bit.
- Accumulates XOR parity over data and parity bits, then presents the word with parity and framing status.
- Sits between an external serial pin and the byte-consuming logic; samples with an internal bit-period counter (no baud tick input).

Parameters:
- CLKS_PER_BIT, 16: clk cycles per serial bit. Must be ≥4 and even.
- DATA_W, 8: data bits per frame, 1..16.
- PARITY_ODD, 0: 0 = even parity expected, 1 = odd parity expected.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- rx  input  1  serial line; idles high; asynchronous to clk.
- data_out  output  DATA_W  last received word, bit0 = first data bit.
- valid  output  1  one-cycle pulse: frame complete; data_out, parity_err and frame_err updated this cycle.
- parity_err  output  1  1 when the XOR of data and parity bits ≠ PARITY_ODD; held until next valid.
- frame_err  output  1  1 when the sampled stop bit was 0; held until next valid.
- busy  output  1  1 in any state other than IDLE.

Behaviour:
- Reset (async assert, sync release): state=IDLE, data_out=0, valid=0, parity_err=0, frame_err=0, busy=0, synchroniser flops=1, counters=0, parity accumulator=0.
- rx passes through a 2-flop synchroniser; rx_s (its output) is the only value used below.
- States: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
- IDLE: when rx_s==0, go to START; clear bit counter, cycle counter and parity accumulator.
- START: count to CLKS_PER_BIT/2-1 (mid-bit), then sample.
  - rx_s==0: go to DATA, clear cycle counter.
  - rx_s==1: glitch; return to IDLE, no valid.
- DATA: at each cycle count CLKS_PER_BIT-1, sample rx_s.
  - Shift the sample into the shift register at the MSB end, LSB-first ordering.
  - XOR the sample into the accumulator.
  - Increment the bit counter.
  - After DATA_W samples, go to PARITY.
- PARITY: sample after CLKS_PER_BIT cycles; XOR the sample into the accumulator; go to STOP.
- STOP: sample after CLKS_PER_BIT cycles.
  - Next cycle: valid=1; data_out=shift register; parity_err=accumulator^PARITY_ODD; frame_err=~stop_sample.
  - Stop==1: go to IDLE.
  - Stop==0: go to WAIT_HIGH.
- WAIT_HIGH: hold until rx_s==1 so a break or stuck-low line yields exactly one frame_err frame; then go to IDLE.
- Latency: with T0 = first cycle IDLE sees rx_s==0, valid is high at cycle T0 + CLKS_PER_BIT/2 + (DATA_W+2)*CLKS_PER_BIT. For defaults this is T0+168.
- valid is never asserted for two consecutive cycles.
- data_out and the error flags change only in the valid cycle.
- Back-to-back frames: a start edge after the stop mid-sample is accepted. IDLE must be re-entered within one cycle of that sample so a frame with a minimal half-bit stop is received.
- rx changing during the ignored part of a bit has no effect; only mid-bit samples matter.
- Reset mid-frame: the partial frame is discarded, no valid, all outputs return to reset values.

Test Plan:
- Defaults; send 0xA5 with parity 0 and stop 1 -> single valid at T0+168, data_out=0xA5, parity_err=0, frame_err=0, busy falls one cycle after valid.
- Send 0xA5 with parity 1 -> data_out=0xA5, parity_err=1, frame_err=0. Repeat with PARITY_ODD=1 -> parity_err=0.
- Send 0x3C with stop bit 0, then hold rx low for 40 bit-times -> exactly one valid with frame_err=1, busy stays 1 until rx returns high, no further valid.
- Low glitch of 4 clks on idle rx -> no valid, busy returns to 0 within CLKS_PER_BIT/2+2 cycles, data_out unchanged.
- Frames 0x00 then 0xFF back-to-back with minimal stop -> two valids exactly 11*CLKS_PER_BIT cycles apart, data_out 0x00 then 0xFF, no errors.
- Assert rst_n=0 during data bit 3 of a frame -> outputs zero immediately (async). Then send 0x5A after release -> received correctly, no error.

Source files
------------

// File: rtl/parity_uart_rx.sv
// Async-serial frame receiver: start, DATA_W data bits LSB-first, parity, stop.
// Reports the word plus XOR parity and framing status with a one-cycle valid pulse.
module parity_uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned PARITY_ODD   = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx,
  output logic [DATA_W-1:0] data_out,
  output logic              valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam int unsigned BW = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);
  localparam logic          ODD_BIT = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  state_t            state_q;
  logic [1:0]        sync_q;
  logic              rx_s;
  logic [CW-1:0]     cnt_q;
  logic [BW-1:0]     bit_q;
  logic [DATA_W-1:0] shift_q;
  logic              par_q;

  assign rx_s = sync_q[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      sync_q     <= 2'b11;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      data_out   <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], rx};
      valid  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          busy <= ~rx_s;
          if (!rx_s) begin
            state_q <= S_START;
            cnt_q   <= '0;
            bit_q   <= '0;
            par_q   <= 1'b0;
          end
        end
        S_START: begin
          if (cnt_q == HALF_M1) begin
            cnt_q <= '0;
            if (rx_s) begin
              state_q <= S_IDLE;
              busy    <= 1'b0;
            end else begin
              state_q <= S_DATA;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DATA: begin
          if (cnt_q == FULL_M1) begin
            cnt_q   <= '0;
            shift_q <= (shift_q >> 1) | (DATA_W'(rx_s) << (DATA_W - 1));
            par_q   <= par_q ^ rx_s;
            bit_q   <= bit_q + 1'b1;
            if (bit_q == LAST_BIT) state_q <= S_PARITY;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_PARITY: begin
          if (cnt_q == FULL_M1) begin
            cnt_q   <= '0;
            par_q   <= par_q ^ rx_s;
            state_q <= S_STOP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_STOP: begin
          // busy stays high through the valid cycle; IDLE clears it next edge
          if (cnt_q == FULL_M1) begin
            cnt_q      <= '0;
            valid      <= 1'b1;
            data_out   <= shift_q;
            parity_err <= par_q ^ ODD_BIT;
            frame_err  <= ~rx_s;
            state_q    <= rx_s ? S_IDLE : S_WAIT_HIGH;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_WAIT_HIGH: begin
          if (rx_s) begin
            state_q <= S_IDLE;
            busy    <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_parity_uart_rx.sv
// Randomised frame bench for parity_uart_rx: even- and odd-parity instances share one serial line.
module tb_parity_uart_rx;

  localparam int C   = 16;
  localparam int H   = C / 2;
  localparam int DW  = 8;
  // line driven low just after edge E: two synchroniser flops, then IDLE sees it at E+3
  localparam int LAT = 3 + H + (DW + 2) * C;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rx;
  logic [DW-1:0] dout_e, dout_o;
  logic          val_e, val_o, pe_e, pe_o, fe_e, fe_o, busy_e, busy_o;

  parity_uart_rx #(.CLKS_PER_BIT(C), .DATA_W(DW), .PARITY_ODD(0)) u_even (
    .clk(clk), .rst_n(rst_n), .rx(rx), .data_out(dout_e), .valid(val_e),
    .parity_err(pe_e), .frame_err(fe_e), .busy(busy_e)
  );

  parity_uart_rx #(.CLKS_PER_BIT(C), .DATA_W(DW), .PARITY_ODD(1)) u_odd (
    .clk(clk), .rst_n(rst_n), .rx(rx), .data_out(dout_o), .valid(val_o),
    .parity_err(pe_o), .frame_err(fe_o), .busy(busy_o)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  int unsigned   q_cyc[$];
  logic [DW-1:0] q_dat[$], q_dat_o[$];
  logic          q_pe[$], q_pe_o[$], q_fe[$], q_bnext[$];
  logic          val_prev = 1'b0, rst_prev = 1'b0;
  logic [DW-1:0] dout_prev = '0;
  logic          dbl_valid = 1'b0, pair_bad = 1'b0, dout_glitch = 1'b0;

  always @(negedge clk) begin
    if (val_e) begin
      q_cyc.push_back(cyc);
      q_dat.push_back(dout_e);
      q_dat_o.push_back(dout_o);
      q_pe.push_back(pe_e);
      q_pe_o.push_back(pe_o);
      q_fe.push_back(fe_e);
    end
    if (val_prev) q_bnext.push_back(busy_e);
    if (val_e && val_prev) dbl_valid <= 1'b1;
    if (val_e !== val_o || busy_e !== busy_o || fe_e !== fe_o) pair_bad <= 1'b1;
    if (rst_n && rst_prev && !val_e && dout_e !== dout_prev) dout_glitch <= 1'b1;
    val_prev  <= val_e;
    rst_prev  <= rst_n;
    dout_prev <= dout_e;
  end

  int unsigned t_start;
  int unsigned last_vcyc;

  task automatic send_bit(input logic b);
    rx = b;
    repeat (C) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input logic p, input logic s,
                            input int gap, input int tail_lo);
    t_start = cyc;
    send_bit(1'b0);
    for (int i = 0; i < DW; i++) send_bit(d[i]);
    send_bit(p);
    send_bit(s);
    for (int i = 0; i < tail_lo; i++) send_bit(1'b0);
    rx = 1'b1;
    for (int i = 0; i < gap; i++) send_bit(1'b1);
  endtask

  task automatic clear_queues();
    q_cyc.delete(); q_dat.delete(); q_dat_o.delete();
    q_pe.delete(); q_pe_o.delete(); q_fe.delete(); q_bnext.delete();
  endtask

  task automatic expect_frame(input string tag, input logic [DW-1:0] d, input logic p, input logic s);
    int  n;
    logic ones;
    n    = q_cyc.size();
    ones = ^d ^ p;
    check({tag, "_nvalid"}, n, 1);
    if (n > 0) begin
      last_vcyc = q_cyc[0];
      check({tag, "_latency"}, q_cyc[0] - t_start, LAT);
      check({tag, "_data"}, q_dat[0], d);
      check({tag, "_data_odd"}, q_dat_o[0], d);
      check({tag, "_perr_even"}, q_pe[0], ones != 1'b0);
      check({tag, "_perr_odd"}, q_pe_o[0], ones != 1'b1);
      check({tag, "_ferr"}, q_fe[0], !s);
      if (q_bnext.size() > 0) check({tag, "_busy_after"}, q_bnext[0], !s);
      else check({tag, "_busy_after_seen"}, 0, 1);
    end
    clear_queues();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_data"}, {dout_o, dout_e}, 0);
    check({tag, "_flags"}, {val_e, pe_e, fe_e, busy_e, val_o, pe_o, fe_o, busy_o}, 0);
  endtask

  initial begin
    logic [DW-1:0] d, held;
    logic          p, s;
    int            gap;
    int unsigned   first_v;

    rst_n = 1'b0;
    rx    = 1'b1;
    #1;
    check_zero("reset");
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    send_frame(8'hA5, 1'b0, 1'b1, 1, 0);
    expect_frame("a5_good", 8'hA5, 1'b0, 1'b1);
    send_frame(8'hA5, 1'b1, 1'b1, 1, 0);
    expect_frame("a5_badpar", 8'hA5, 1'b1, 1'b1);

    for (int k = 0; k < 20; k++) begin
      d   = DW'($urandom);
      p   = 1'($urandom_range(0, 1));
      s   = ($urandom_range(0, 3) != 0);
      gap = $urandom_range(0, 2);
      if (!s && gap == 0) gap = 1;
      send_frame(d, p, s, gap, 0);
      expect_frame("rand", d, p, s);
    end

    send_frame(8'h3C, 1'b0, 1'b0, 0, 40);
    check("break_busy_held", busy_e, 1);
    expect_frame("break", 8'h3C, 1'b0, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    check("break_busy_release", busy_e, 0);
    repeat (C) @(posedge clk);
    #1;
    check("break_no_extra_valid", q_cyc.size(), 0);

    held = dout_e;
    rx   = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (9) @(posedge clk);
    #1;
    check("glitch_busy_low", busy_e, 0);
    repeat (2 * C) @(posedge clk);
    #1;
    check("glitch_no_valid", q_cyc.size(), 0);
    check("glitch_data_held", dout_e, held);

    send_frame(8'h00, 1'b0, 1'b1, 0, 0);
    expect_frame("b2b_first", 8'h00, 1'b0, 1'b1);
    first_v = last_vcyc;
    send_frame(8'hFF, 1'b0, 1'b1, 1, 0);
    expect_frame("b2b_second", 8'hFF, 1'b0, 1'b1);
    check("b2b_spacing", last_vcyc - first_v, 11 * C);

    d = 8'h96;
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(d[i]);
    rx = d[3];
    repeat (H) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_zero("midframe_reset");
    repeat (3) @(posedge clk);
    #1;
    rx    = 1'b1;
    rst_n = 1'b1;
    repeat (2 * C) @(posedge clk);
    #1;
    check("midframe_no_valid", q_cyc.size(), 0);
    clear_queues();
    send_frame(8'h5A, 1'b0, 1'b1, 1, 0);
    expect_frame("after_reset", 8'h5A, 1'b0, 1'b1);

    check("no_double_valid", dbl_valid, 0);
    check("instances_agree", pair_bad, 0);
    check("data_only_on_valid", dout_glitch, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
